axil_slave_regmem: RTL and testbench
====================================

# axil_slave_regmem

AXI4-Lite slave register memory that terminates the M_AXI port of the shell's controller AXI master, in place of the simulation slave VIP. Accepts single-beat writes with byte strobes into a DEPTH-word register array, serves single-beat reads, flags out-of-range accesses with SLVERR, and exposes saturating transaction counters for status readout. One outstanding write and one outstanding read at a time; the read and write paths run independently.

## Interface
- ADDR_WIDTH, 32, byte address width of AW/AR channels
- DEPTH, 16, number of 32-bit words; must be a power of two, 2 to 256
- ACLK  in  1  sole clock; all logic rising-edge
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address (byte)
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables, bit i covers WDATA[8i+7:8i]
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address (byte)
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- WR_COUNT  out  16  completed B handshakes, saturates at 0xFFFF
- RD_COUNT  out  16  completed R handshakes, saturates at 0xFFFF

## Operation
- Word index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored. Index >= DEPTH is out of range.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP.
  - W_IDLE: AWREADY=1, WREADY=1. AW only -> W_HAVE_A; W only -> W_HAVE_D; both same edge -> W_COMMIT.
  - W_HAVE_A: AWREADY=0, WREADY=1; W handshake -> W_COMMIT. W_HAVE_D symmetric.
  - W_COMMIT (one cycle, both READYs 0): in range -> bytes with WSTRB=1 written, others kept, BRESP=00; out of range -> no write, BRESP=10. -> W_RESP with BVALID=1.
  - W_RESP: BVALID held, BRESP stable until BREADY; on handshake -> W_IDLE, WR_COUNT+1.
- Read FSM states: R_IDLE (ARREADY=1, RVALID=0), R_RESP (ARREADY=0, RVALID=1).
  - AR handshake: RDATA = word (in range, RRESP=00) or 0x00000000 (out of range, RRESP=10), registered; -> R_RESP.
  - R_RESP: RDATA/RRESP stable until RREADY; on handshake -> R_IDLE, RD_COUNT+1.
- Counters increment by 1 per handshake, hold at 0xFFFF.

## Timing
- Reset (async assert, deassert sync to ACLK): all memory words 0, both FSMs idle, AWREADY=WREADY=ARREADY=0 during reset and 1 from first edge after release, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, counters 0.
- Write latency: last of AW/W handshake at edge N -> memory updated and BVALID=1 at edge N+1. Earliest next AWREADY: cycle after B handshake edge.
- Read latency: AR handshake at edge N -> RVALID=1 with data after edge N. Back-to-back with RREADY held 1: one read per 2 cycles.
- Read/write collision: AR handshake on the same edge as W_COMMIT to the same word returns the old (pre-write) value.
- WVALID/AWVALID may arrive in either order with arbitrary gap; data held in internal registers.
- BREADY/RREADY low: outputs hold indefinitely; no new address accepted on that channel.
- Reset mid-transaction: pending response discarded, VALIDs drop asynchronously, memory cleared.

## Test plan
- Reset: ARESET=1 5 cycles, release -> all READY=1 next cycle, VALIDs 0, read of idx 0..15 returns 0x00000000 OKAY.
- Full write/readback: AW=0x08, W=0xDEADBEEF, STRB=0xF same cycle -> BVALID 2 edges later, BRESP=00; AR=0x08 -> RDATA=0xDEADBEEF, RRESP=00; WR_COUNT=1, RD_COUNT=1.
- Strobes and order: W first (0x11223344, STRB=0x5) then AW=0x08 3 cycles later -> readback 0xDE22BE44.
- Out of range (DEPTH=16): write AW=0x40 -> BRESP=10, no word changed; AR=0x40 -> RDATA=0, RRESP=10.
- Backpressure: BREADY=0 for 10 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; RREADY=0 similarly holds RDATA, ARREADY=0.
- Collision and saturation: AR to idx 2 on W_COMMIT edge writing 0xCAFEF00D to idx 2 -> old value returned, next read 0xCAFEF00D; 65540 writes -> WR_COUNT=0xFFFF.

Source files
------------

// File: rtl/axil_slave_regmem.sv
// AXI4-Lite slave backed by a DEPTH-word register array with byte strobes,
// SLVERR on out-of-range word indices and saturating handshake counters.
module axil_slave_regmem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter logic [15:0] CNT_MAX    = 16'hFFFF
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [15:0]           WR_COUNT,
  output logic [15:0]           RD_COUNT
);

  localparam int unsigned IDXW = $clog2(DEPTH);

  typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t          wstate;
  rstate_t          rstate;
  logic [31:0]      mem [DEPTH];

  logic             awready_q, wready_q, bvalid_q;
  logic [1:0]       bresp_q;
  logic             arready_q, rvalid_q;
  logic [1:0]       rresp_q;
  logic [31:0]      rdata_q;
  logic [15:0]      wr_cnt_q, rd_cnt_q;

  logic [IDXW-1:0]  aw_idx_q;
  logic             aw_oor_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;

  logic             aw_hs, w_hs, ar_hs;
  logic [IDXW-1:0]  aw_idx, ar_idx;
  logic             aw_oor, ar_oor;
  logic             unused_bits;

  assign aw_hs  = S_AXI_AWVALID & awready_q;
  assign w_hs   = S_AXI_WVALID  & wready_q;
  assign ar_hs  = S_AXI_ARVALID & arready_q;

  // Any set bit above the index field puts the word index at or beyond DEPTH.
  assign aw_idx = S_AXI_AWADDR[IDXW+1:2];
  assign aw_oor = |S_AXI_AWADDR[ADDR_WIDTH-1:IDXW+2];
  assign ar_idx = S_AXI_ARADDR[IDXW+1:2];
  assign ar_oor = |S_AXI_ARADDR[ADDR_WIDTH-1:IDXW+2];

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write channel; also the sole writer of the register array.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate    <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      wr_cnt_q  <= '0;
      aw_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_idx_q <= aw_idx;
        aw_oor_q <= aw_oor;
      end
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      case (wstate)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wstate    <= W_COMMIT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else if (aw_hs) begin
            wstate    <= W_HAVE_A;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            wstate    <= W_HAVE_D;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_HAVE_A: if (w_hs) begin
          wstate   <= W_COMMIT;
          wready_q <= 1'b0;
        end
        W_HAVE_D: if (aw_hs) begin
          wstate    <= W_COMMIT;
          awready_q <= 1'b0;
        end
        W_COMMIT: begin
          if (!aw_oor_q) begin
            for (int unsigned b = 0; b < 4; b++)
              if (wstrb_q[b]) mem[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
          end
          bresp_q  <= aw_oor_q ? 2'b10 : 2'b00;
          bvalid_q <= 1'b1;
          wstate   <= W_RESP;
        end
        W_RESP: if (S_AXI_BREADY) begin
          bvalid_q  <= 1'b0;
          bresp_q   <= 2'b00;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          wstate    <= W_IDLE;
          if (wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Reads sample the array before any same-edge commit lands (old data wins).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate    <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      rd_cnt_q  <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= ar_oor ? 32'h0000_0000 : mem[ar_idx];
            rresp_q   <= ar_oor ? 2'b10 : 2'b00;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate    <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: if (S_AXI_RREADY) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          rstate    <= R_IDLE;
          if (rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign WR_COUNT      = wr_cnt_q;
  assign RD_COUNT      = rd_cnt_q;

endmodule

// File: tb/tb_axil_slave_regmem.sv
// Directed bench for axil_slave_regmem: reset, strobed writes, ordering,
// range errors, backpressure, read/write collision, reset abort, saturation.
module tb_axil_slave_regmem;

  localparam logic [15:0] CNT_MAX_TB = 16'd40;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [15:0] WR_COUNT, RD_COUNT;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_wr = '0;
  logic [15:0] exp_rd = '0;
  logic [31:0] rd;
  logic [1:0]  rsp;

  always #5 ACLK = ~ACLK;

  axil_slave_regmem #(.ADDR_WIDTH(32), .DEPTH(16), .CNT_MAX(CNT_MAX_TB)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .WR_COUNT(WR_COUNT), .RD_COUNT(RD_COUNT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX_TB) ? v : v + 16'd1;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_aw(input logic [31:0] addr);
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge ACLK); if (S_AXI_AWREADY) break; end
    if (!S_AXI_AWREADY) check("aw_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge ACLK); if (S_AXI_WREADY) break; end
    if (!S_AXI_WREADY) check("w_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1 S_AXI_WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge ACLK); if (S_AXI_ARREADY) break; end
    if (!S_AXI_ARREADY) check("ar_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1 S_AXI_ARVALID = 1'b0;
  endtask

  task automatic write_both(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK); if (S_AXI_AWREADY && S_AXI_WREADY) break;
    end
    if (!(S_AXI_AWREADY && S_AXI_WREADY)) check("aww_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge ACLK); if (S_AXI_BVALID) break; end
    if (!S_AXI_BVALID) check("b_timeout", 32'd0, 32'd1);
    resp = S_AXI_BRESP;
    @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
    exp_wr = sat_inc(exp_wr);
  endtask

  task automatic get_r(output logic [31:0] data, output logic [1:0] resp);
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge ACLK); if (S_AXI_RVALID) break; end
    if (!S_AXI_RVALID) check("r_timeout", 32'd0, 32'd1);
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
    exp_rd = sat_inc(exp_rd);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    write_both(addr, data, strb);
    get_b(resp);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    send_ar(addr);
    get_r(data, resp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    // Reset and post-reset state
    repeat (5) @(posedge ACLK);
    #1 check("rst_hold_flags", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                    S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
    @(negedge ACLK) ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("rst_readys", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'h7);
    check("rst_valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
    check("rst_resp_data", S_AXI_RDATA | 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
    check("rst_counts", {WR_COUNT, RD_COUNT}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      do_read(32'(i * 4), rd, rsp);
      check("rst_mem", rd, 32'd0);
      check("rst_mem_resp", 32'(rsp), 32'd0);
    end

    // Full write with exact latency, then readback
    S_AXI_AWADDR = 32'h08; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    check("wr_commit_cycle", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'd0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(posedge ACLK); #1;
    check("wr_bvalid_lat", 32'({S_AXI_BVALID, S_AXI_BRESP}), 32'h4);
    get_b(rsp);
    check("wr_count_1", 32'(WR_COUNT), 32'(exp_wr));
    do_read(32'h08, rd, rsp);
    check("rd_full", rd, 32'hDEADBEEF);
    check("rd_full_resp", 32'(rsp), 32'd0);
    check("rd_count", 32'(RD_COUNT), 32'(exp_rd));

    // W before AW with partial strobes
    send_w(32'h11223344, 4'h5);
    check("have_d_readys", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h2);
    repeat (3) @(posedge ACLK);
    #1 send_aw(32'h08);
    get_b(rsp);
    check("strb_bresp", 32'(rsp), 32'd0);
    do_read(32'h08, rd, rsp);
    check("strb_data", rd, 32'hDE22BE44);

    // Range boundaries and ignored low address bits
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, rsp);
    check("oor_bresp", 32'(rsp), 32'h2);
    do_read(32'h08, rd, rsp);
    check("oor_no_write_2", rd, 32'hDE22BE44);
    do_read(32'h3C, rd, rsp);
    check("oor_no_write_15", rd, 32'd0);
    do_read(32'h40, rd, rsp);
    check("oor_rdata", rd, 32'd0);
    check("oor_rresp", 32'(rsp), 32'h2);
    do_write(32'h3C, 32'hA5A5A5A5, 4'hF, rsp);
    check("last_idx_bresp", 32'(rsp), 32'd0);
    do_read(32'h3C, rd, rsp);
    check("last_idx_data", rd, 32'hA5A5A5A5);
    do_read(32'h0B, rd, rsp);
    check("low_bits_ignored", rd, 32'hDE22BE44);

    // Write response backpressure
    write_both(32'h0C, 32'h12345678, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      check("b_hold", 32'({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}), 32'h10);
    end
    get_b(rsp);
    check("b_hold_resp", 32'(rsp), 32'd0);

    // Read response backpressure
    send_ar(32'h0C);
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      check("r_hold_data", S_AXI_RDATA, 32'h12345678);
      check("r_hold_flags", 32'({S_AXI_RVALID, S_AXI_RRESP, S_AXI_ARREADY}), 32'h8);
    end
    get_r(rd, rsp);
    check("r_hold_after", 32'(S_AXI_RVALID), 32'd0);

    // AR on the commit edge of a write to the same word sees old data
    S_AXI_AWADDR = 32'h08; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 32'h08; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("coll_valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'h3);
    check("coll_old_data", S_AXI_RDATA, 32'hDE22BE44);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    exp_wr = sat_inc(exp_wr); exp_rd = sat_inc(exp_rd);
    do_read(32'h08, rd, rsp);
    check("coll_new_data", rd, 32'hCAFEF00D);
    check("coll_counts", {WR_COUNT, RD_COUNT}, {exp_wr, exp_rd});

    // Reset during pending responses
    write_both(32'h10, 32'h55AA55AA, 4'hF);
    send_ar(32'h10);
    check("abort_pending", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'h3);
    #2 ARESET = 1'b1;
    #1 check("abort_async", 32'({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY}), 32'd0);
    @(negedge ACLK) ARESET = 1'b0;
    @(posedge ACLK); #1;
    exp_wr = '0; exp_rd = '0;
    check("abort_counts", {WR_COUNT, RD_COUNT}, 32'd0);
    do_read(32'h10, rd, rsp);
    check("abort_mem_4", rd, 32'd0);
    do_read(32'h08, rd, rsp);
    check("abort_mem_2", rd, 32'd0);

    // Counter saturation
    for (int i = 0; i < 45; i++) begin
      do_write(32'h14, 32'(i), 4'hF, rsp);
      do_read(32'h14, rd, rsp);
      if (i == 38) check("cnt_below_max", {WR_COUNT, RD_COUNT}, {exp_wr, exp_rd});
    end
    check("wr_saturated", 32'(WR_COUNT), 32'(CNT_MAX_TB));
    check("rd_saturated", 32'(RD_COUNT), 32'(CNT_MAX_TB));
    check("sat_last_data", rd, 32'd44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
